uart_tx_param: RTL

Parametrised UART transmitter for the serial path. Provides configurable baud divisor, data width and stop-bit count, and an optional parity bit. A one-entry holding register lets the host queue the next byte while the current frame shifts out, so back-to-back frames go out with no idle gap. Sits between the command/response logic and the TX pin.

---
 rtl/uart_pkg.sv | 20 ++
 rtl/uart_baud_cnt.sv | 40 ++++
 rtl/uart_tx_param.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART TX types and constants: FSM state encoding, idle line level,
// and the baud counter width helper.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

  localparam logic UART_IDLE_LVL = 1'b1;

  // Counter width able to hold CLK_DIV-1.
  function automatic int baud_cnt_w(input int clk_div);
    return (clk_div < 2) ? 1 : $clog2(clk_div);
  endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period counter: counts 0..CLK_DIV-1 while enabled and flags the last cycle.
// Latency: bit_end is combinational from the count flop; clr holds the count at zero.
// Backpressure: none, free-running while en=1.
module uart_baud_cnt
  import uart_pkg::*;
#(
  parameter int CLK_DIV = 44
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic bit_end
);

  localparam int            CW   = baud_cnt_w(CLK_DIV);
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
    end
  end

  assign bit_end = en & (cnt_q == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_tx_param.sv
// UART transmitter with configurable divisor, data width and stop bits; parity bit when UART_TX_PARITY_EN is defined.
// Latency: byte accepted in IDLE drives the start bit the next cycle; queued frames follow with no idle gap.
// Backpressure: one-entry holding register; tx_rdy low while it is full and trmt is then ignored.
module uart_tx_param
  import uart_pkg::*;
#(
  parameter int CLK_DIV   = 44,
  parameter int DATA_BITS = 8,
  parameter int STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 trmt,
  input  logic [DATA_BITS-1:0] tx_data,
`ifdef UART_TX_PARITY_EN
  input  logic                 parity_odd,
`endif
  output logic                 TX,
  output logic                 tx_rdy,
  output logic                 tx_busy,
  output logic                 tx_done
);

  localparam logic [3:0] LAST_DATA = 4'(DATA_BITS - 1);
  localparam logic [3:0] LAST_STOP = 4'(STOP_BITS - 1);

  tx_state_t            state_q, state_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] hold_q, hold_d;
  logic [DATA_BITS-1:0] ld_data;
  logic                 hold_vld_q, hold_vld_d;
  logic [3:0]           idx_q, idx_d;
  logic                 tx_q, tx_d;
  logic                 bit_end, accept, load, frame_end;

  uart_baud_cnt #(
    .CLK_DIV(CLK_DIV)
  ) u_baud (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (state_q == IDLE),
    .en     (state_q != IDLE),
    .bit_end(bit_end)
  );

  assign accept    = trmt & ~hold_vld_q;
  assign frame_end = (state_q == STOP) & bit_end & (idx_q == LAST_STOP);
  // A queued byte always goes before a new request.
  assign ld_data   = hold_vld_q ? hold_q : tx_data;

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    idx_d      = idx_q;
    hold_d     = hold_q;
    hold_vld_d = hold_vld_q;
    load       = 1'b0;
    case (state_q)
      IDLE: load = accept | hold_vld_q;
      START: begin
        if (bit_end) begin
          state_d = DATA;
          idx_d   = '0;
        end
      end
      DATA: begin
        if (bit_end) begin
          shift_d = shift_q >> 1;
          if (idx_q == LAST_DATA) begin
`ifdef UART_TX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
            idx_d = '0;
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end
      end
      PARITY: begin
        if (bit_end) begin
          state_d = STOP;
          idx_d   = '0;
        end
      end
      STOP: begin
        if (bit_end) begin
          if (idx_q == LAST_STOP) begin
            state_d = IDLE;
            load    = accept | hold_vld_q;
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (load) begin
      state_d    = START;
      shift_d    = ld_data;
      idx_d      = '0;
      hold_vld_d = 1'b0;
    end else if (accept) begin
      hold_d     = tx_data;
      hold_vld_d = 1'b1;
    end
  end

`ifdef UART_TX_PARITY_EN
  logic par_q, par_d;

  always_comb begin
    par_d = par_q;
    if (load) begin
      par_d = (^ld_data) ^ parity_odd;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      par_q <= 1'b0;
    end else begin
      par_q <= par_d;
    end
  end
`endif

  // Line level is computed from the next state so TX comes straight off a flop.
  always_comb begin
    tx_d = UART_IDLE_LVL;
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  tx_d = par_d;
`endif
      default: tx_d = UART_IDLE_LVL;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      hold_q     <= '0;
      hold_vld_q <= 1'b0;
      idx_q      <= '0;
      tx_q       <= UART_IDLE_LVL;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      hold_q     <= hold_d;
      hold_vld_q <= hold_vld_d;
      idx_q      <= idx_d;
      tx_q       <= tx_d;
    end
  end

  assign TX      = tx_q;
  assign tx_rdy  = ~hold_vld_q;
  assign tx_busy = (state_q != IDLE);
  assign tx_done = frame_end;

endmodule
